halton_point_buffer: RTL and testbench
======================================

// Module: halton_point_buffer
// PURPOSE
//  Downstream stage of the 2-D Halton generator (bases [2,3]). Throttles the generator's pop_enable,
//  captures each {halton_out_0, halton_out_1} point on valid into a FIFO, and re-issues points on a
//  ready/valid stream to point consumers. Also sequences generator reseeds: drains in-flight points, flushes the FIFO, pulses reseed.
// PARAMETERS
//  DEPTH        8   FIFO entries; power of two, >= 4
//  MARGIN       2   slots kept free for points already in flight from the generator; < DEPTH
//  DRAIN_CYCLES 4   cycles in-flight generator output is discarded during reseed; >= generator latency
//  WIDTH        32  coordinate width
// PORTS
//  clk               in   1      clock, all logic on rising edge
//  rst               in   1      synchronous, active-high reset
//  gen_pop_enable    out  1      to generator pop_enable
//  gen_reseed_enable out  1      to generator reseed_enable (1-cycle pulse)
//  gen_seed          out  32     to generator seed
//  gen_valid         in   1      generator valid; one point per asserted cycle
//  gen_x / gen_y     in   WIDTH  generator halton_out_0 / halton_out_1
//  reseed_req        in   1      request reseed, sampled only when reseed_busy=0
//  reseed_seed       in   32     seed captured with reseed_req
//  reseed_busy       out  1      high from the edge that accepts reseed_req through RESEED
//  out_valid         out  1      point available
//  out_ready         in   1      consumer accepts when out_valid&&out_ready
//  out_x / out_y     out  WIDTH  point coordinates
//  drop_err          out  1      sticky: a gen_valid point arrived while FIFO full
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; count=0; state RUN; drop_err cleared.
//  FIFO: registered first-word-fall-through; point written at edge N -> out_valid=1 after edge N (1-cycle latency).
//  out_x/out_y stable while out_valid&&!out_ready. Order preserved.
//  gen_pop_enable = (state==RUN) && (count + MARGIN < DEPTH); combinational from registered count.
//  Push = gen_valid && state==RUN && (!full || pop). Push and pop in the same cycle when full: both happen, count unchanged.
//  gen_valid && full && !pop in RUN: point discarded, drop_err<=1 (cleared only by rst).
//  Empty + push: no bypass; out_valid rises next cycle. Pointers wrap mod DEPTH.
//  FSM: RUN -> DRAIN on reseed_req; seed latched into gen_seed.
//    DRAIN: gen_pop_enable=0, gen_valid ignored, out_valid=0, FIFO cleared on entry.
//    DRAIN lasts DRAIN_CYCLES cycles, then RESEED.
//    RESEED: gen_reseed_enable=1 for exactly one cycle -> RUN.
//  reseed_req while reseed_busy: ignored. gen_seed holds last latched seed.
//  rst at any time, including mid-DRAIN/RESEED: returns to reset state on the same edge; no reseed pulse issued.
// CONFIGURATION
//  HALTON_PTBUF_STATS_EN defined: adds ports stat_delivered[31:0] (out handshakes) and stat_dropped[15:0] (discarded points).
//    Both wrap at max; cleared by rst and on entering DRAIN.
//  Not defined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  halton_pkg: typedef struct packed {logic [WIDTH-1:0] x, y;} halton_point_t; typedef enum {RUN,DRAIN,RESEED} ptbuf_state_t; DEPTH/MARGIN defaults.
//  Sub-module halton_point_fifo (storage, pointers, count, full/empty, clear); FSM, throttle, stats in top.
// TESTING (bench uses generator model, scales [11,7])
//  1 Stream 10 points, out_ready=1 -> out sequence [1024,729],[512,1458]..[640,810] in order; drop_err=0.
//  2 out_ready=0 -> gen_pop_enable falls at count=DEPTH-MARGIN=6; 2 in-flight points absorbed; count=8, drop_err=0.
//  3 Force gen_valid when full, out_ready=0 -> point discarded, drop_err=1 sticky; FIFO contents unchanged.
//  4 Full FIFO, out_ready=1 and gen_valid together -> count stays 8; no drop.
//  5 reseed_req seed=5 mid-stream -> DRAIN 4 cycles, out_valid=0, one gen_reseed_enable pulse with gen_seed=5; next output [768,486] (k=6).
//  6 rst asserted during DRAIN -> next edge: all outputs 0, state RUN, no gen_reseed_enable pulse.

Source files
------------

// File: rtl/halton_pkg.sv
// Shared types and defaults for the Halton point buffer (bases 2,3).
// Optional statistics counters are enabled with HALTON_PTBUF_STATS_EN.
package halton_pkg;

  localparam int HALTON_WIDTH       = 32;
  localparam int PTBUF_DEPTH        = 8;
  localparam int PTBUF_MARGIN       = 2;
  localparam int PTBUF_DRAIN_CYCLES = 4;

  typedef struct packed {
    logic [HALTON_WIDTH-1:0] x;
    logic [HALTON_WIDTH-1:0] y;
  } halton_point_t;

  typedef enum logic [1:0] {RUN, DRAIN, RESEED} ptbuf_state_t;

endpackage

// File: rtl/halton_point_fifo.sv
// Registered first-word-fall-through point FIFO: write at edge N is readable after edge N.
// Push is refused only when full without a same-cycle pop; clear empties it in one edge.
module halton_point_fifo
  import halton_pkg::*;
#(
  parameter int DEPTH = PTBUF_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  halton_point_t wr_dat,
  input  logic          pop,
  output halton_point_t rd_dat,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);

  halton_point_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_dat  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  // Pointers are exactly AW bits wide, so they wrap mod DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/halton_point_buffer.sv
// Throttles a 2-D Halton generator into a FIFO and re-issues points on ready/valid; 1-cycle latency.
// Reseed drains in-flight points, flushes, pulses reseed; stats ports under HALTON_PTBUF_STATS_EN.
module halton_point_buffer
  import halton_pkg::*;
#(
  parameter int DEPTH        = PTBUF_DEPTH,
  parameter int MARGIN       = PTBUF_MARGIN,
  parameter int DRAIN_CYCLES = PTBUF_DRAIN_CYCLES,
  parameter int WIDTH        = HALTON_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  output logic             gen_pop_enable,
  output logic             gen_reseed_enable,
  output logic [31:0]      gen_seed,
  input  logic             gen_valid,
  input  logic [WIDTH-1:0] gen_x,
  input  logic [WIDTH-1:0] gen_y,
  input  logic             reseed_req,
  input  logic [31:0]      reseed_seed,
  output logic             reseed_busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
`ifdef HALTON_PTBUF_STATS_EN
  output logic [31:0]      stat_delivered,
  output logic [15:0]      stat_dropped,
`endif
  output logic             drop_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DRAIN_CYCLES + 1);

  ptbuf_state_t  state;
  logic [CW-1:0] drain_cnt;
  halton_point_t wr_dat;
  halton_point_t rd_dat;
  logic          fifo_empty;
  logic          fifo_full;
  logic [AW:0]   fifo_count;
  logic          running;
  logic          push;
  logic          pop;
  logic          drop;
  logic          accept;

  assign running = (state == RUN);
  assign accept  = running && reseed_req;
  assign push    = running && gen_valid;
  assign pop     = out_valid && out_ready;
  assign drop    = push && fifo_full && !pop;
  assign wr_dat  = '{x: gen_x, y: gen_y};

  // Gated by rst so the generator is neither popped nor reseeded while held in reset.
  assign gen_pop_enable    = !rst && running && ((int'(fifo_count) + MARGIN) < DEPTH);
  assign gen_reseed_enable = !rst && (state == RESEED);
  assign reseed_busy       = !running;
  assign out_valid         = running && !fifo_empty;
  assign out_x             = rd_dat.x;
  assign out_y             = rd_dat.y;

  halton_point_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .push   (push),
    .wr_dat (wr_dat),
    .pop    (pop),
    .rd_dat (rd_dat),
    .empty  (fifo_empty),
    .full   (fifo_full),
    .count  (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      drain_cnt <= '0;
      gen_seed  <= '0;
      drop_err  <= 1'b0;
    end else begin
      if (drop) drop_err <= 1'b1;
      case (state)
        RUN: begin
          if (reseed_req) begin
            state     <= DRAIN;
            gen_seed  <= reseed_seed;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          if (drain_cnt == CW'(DRAIN_CYCLES - 1)) state <= RESEED;
          else drain_cnt <= drain_cnt + 1'b1;
        end
        RESEED:  state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef HALTON_PTBUF_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      stat_delivered <= '0;
      stat_dropped   <= '0;
    end else begin
      if (pop)  stat_delivered <= stat_delivered + 1'b1;
      if (drop) stat_dropped   <= stat_dropped + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_halton_point_buffer.sv
// Bench for halton_point_buffer: latency-2 Halton generator model (scales 2^11, 3^7) plus a
// queue-based reference of the buffer rules; directed scenarios followed by random traffic.
module tb_halton_point_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        gen_pop_enable, gen_reseed_enable;
  logic [31:0] gen_seed;
  logic        gen_valid;
  logic [31:0] gen_x, gen_y;
  logic        reseed_req;
  logic [31:0] reseed_seed;
  logic        reseed_busy, out_valid, out_ready, drop_err;
  logic [31:0] out_x, out_y;
`ifdef HALTON_PTBUF_STATS_EN
  logic [31:0] stat_delivered;
  logic [15:0] stat_dropped;
`endif

  always #5 clk = ~clk;

  halton_point_buffer dut (
    .clk               (clk),
    .rst               (rst),
    .gen_pop_enable    (gen_pop_enable),
    .gen_reseed_enable (gen_reseed_enable),
    .gen_seed          (gen_seed),
    .gen_valid         (gen_valid),
    .gen_x             (gen_x),
    .gen_y             (gen_y),
    .reseed_req        (reseed_req),
    .reseed_seed       (reseed_seed),
    .reseed_busy       (reseed_busy),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_x             (out_x),
    .out_y             (out_y),
`ifdef HALTON_PTBUF_STATS_EN
    .stat_delivered    (stat_delivered),
    .stat_dropped      (stat_dropped),
`endif
    .drop_err          (drop_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rad2(input int k);
    int r = 0;
    int s = 1024;
    for (int i = 0; i < 11; i++) begin
      r += (k % 2) * s;
      k /= 2;
      s /= 2;
    end
    return 32'(r);
  endfunction

  function automatic logic [31:0] rad3(input int k);
    int r = 0;
    int s = 729;
    for (int i = 0; i < 7; i++) begin
      r += (k % 3) * s;
      k /= 3;
      s /= 3;
    end
    return 32'(r);
  endfunction

  // Generator model: pop at edge E yields point k+1 on gen_valid two cycles later.
  int          g_k = 0;
  bit          g_v [2];
  logic [63:0] g_p [2];
  bit          inj = 0;
  logic [63:0] inj_p = '0;

  // Reference: queue contents plus remaining busy cycles (DRAIN_CYCLES + the reseed cycle).
  logic [63:0] mq [$];
  int          m_left = 0;
  logic [31:0] m_seed = '0;
  bit          m_drop = 0;
  logic [31:0] m_dlv = '0;
  logic [15:0] m_dropped = '0;

  logic [63:0] dq [$];
  int          n_pulse = 0;
  logic [31:0] pulse_seed = '0;

  task automatic step();
    int sz;
    bit run, full, pop, pe, re;
    logic [31:0] sd;
    gen_valid = inj || g_v[1];
    {gen_x, gen_y} = inj ? inj_p : (g_v[1] ? g_p[1] : 64'h0);
    #1;
    sz = mq.size();
    check_eq("gen_pop_enable", gen_pop_enable, !rst && m_left == 0 && sz + 2 < 8);
    check_eq("gen_reseed_enable", gen_reseed_enable, !rst && m_left == 1);
    check_eq("reseed_busy", reseed_busy, m_left > 0);
    check_eq("gen_seed", gen_seed, m_seed);
    check_eq("out_valid", out_valid, sz > 0);
    check_eq("drop_err", drop_err, m_drop);
    if (sz > 0) check_eq("out_point", {out_x, out_y}, mq[0]);
`ifdef HALTON_PTBUF_STATS_EN
    check_eq("stat_delivered", stat_delivered, m_dlv);
    check_eq("stat_dropped", stat_dropped, m_dropped);
`endif
    if (out_valid && out_ready) dq.push_back({out_x, out_y});
    if (gen_reseed_enable) begin
      n_pulse++;
      pulse_seed = gen_seed;
    end
    pe = gen_pop_enable;
    re = gen_reseed_enable;
    sd = gen_seed;
    if (rst) begin
      mq.delete();
      m_left = 0; m_seed = '0; m_drop = 0; m_dlv = '0; m_dropped = '0;
    end else begin
      run  = (m_left == 0);
      full = (sz == 8);
      pop  = run && sz > 0 && out_ready;
      if (pop) begin
        void'(mq.pop_front());
        m_dlv++;
      end
      if (run && gen_valid) begin
        if (!full || pop) mq.push_back({gen_x, gen_y});
        else begin
          m_drop = 1;
          m_dropped++;
        end
      end
      if (run && reseed_req) begin
        m_left = 5;
        m_seed = reseed_seed;
        mq.delete();
        m_dlv = '0;
        m_dropped = '0;
      end else if (m_left > 0) begin
        m_left--;
      end
    end
    @(posedge clk);
    #1;
    if (re) begin
      g_k = int'(sd);
      g_v[0] = 0; g_v[1] = 0;
    end else begin
      g_v[1] = g_v[0];
      g_p[1] = g_p[0];
      g_v[0] = pe;
      if (pe) begin
        g_k++;
        g_p[0] = {rad2(g_k), rad3(g_k)};
      end
    end
  endtask

  initial begin
    int n;
    rst = 1; out_ready = 0; reseed_req = 0; reseed_seed = '0;
    gen_valid = 0; gen_x = '0; gen_y = '0;
    g_v[0] = 0; g_v[1] = 0; g_p[0] = '0; g_p[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    repeat (2) step();

    // Stream with consumer always ready.
    rst = 0; out_ready = 1;
    n = 0;
    while (dq.size() < 10 && n < 100) begin step(); n++; end
    check_eq("stream_timeout", dq.size() >= 10, 1);
    if (dq.size() >= 10) begin
      check_eq("first_point", dq[0], {32'd1024, 32'd729});
      check_eq("second_point", dq[1], {32'd512, 32'd1458});
      check_eq("tenth_point", dq[9], {32'd640, 32'd810});
      for (int i = 0; i < 10; i++) check_eq("stream_order", dq[i], {rad2(i + 1), rad3(i + 1)});
    end
    check_eq("drop_after_stream", drop_err, 0);

    // Consumer stalls: throttle plus in-flight points fill exactly to DEPTH.
    out_ready = 0;
    repeat (20) step();
    check_eq("full_pop_enable", gen_pop_enable, 0);
    check_eq("full_no_drop", drop_err, 0);

    // Full FIFO with simultaneous push and pop.
    inj = 1; inj_p = {32'hCAFE0001, 32'hBEEF0001}; out_ready = 1;
    step();
    inj = 0; out_ready = 0;
    repeat (2) step();
    check_eq("push_pop_full_no_drop", drop_err, 0);

    // Push into a full FIFO with no pop is discarded and sticks.
    inj = 1; inj_p = {32'hDEAD0002, 32'hDEAD0003};
    repeat (2) step();
    inj = 0;
    repeat (3) step();
    check_eq("drop_sticky", drop_err, 1);

    // Drain and check the stored order survives, including the injected point at the tail.
    dq.delete();
    out_ready = 1;
    repeat (9) step();
    check_eq("drain_count_min", dq.size() >= 8, 1);
    if (dq.size() >= 8) check_eq("injected_tail", dq[7], {32'hCAFE0001, 32'hBEEF0001});

    // Mid-stream reseed to 5; a second request while busy is ignored.
    repeat (5) step();
    n_pulse = 0;
    reseed_req = 1; reseed_seed = 32'd5;
    step();
    dq.delete();
    reseed_seed = 32'd9;
    step();
    reseed_req = 0;
    n = 0;
    while (dq.size() == 0 && n < 50) begin step(); n++; end
    check_eq("reseed_timeout", dq.size() > 0, 1);
    check_eq("reseed_pulses", n_pulse, 1);
    check_eq("reseed_pulse_seed", pulse_seed, 32'd5);
    if (dq.size() > 0) check_eq("after_reseed_point", dq[0], {32'd768, 32'd486});

    // Reset during DRAIN: no pulse afterwards, seed cleared.
    repeat (4) step();
    reseed_req = 1; reseed_seed = 32'd7;
    step();
    reseed_req = 0;
    repeat (2) step();
    n_pulse = 0;
    rst = 1;
    step();
    rst = 0;
    check_eq("rst_busy", reseed_busy, 0);
    check_eq("rst_seed", gen_seed, 0);
    check_eq("rst_out_valid", out_valid, 0);
    repeat (12) step();
    check_eq("rst_no_pulse", n_pulse, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      out_ready   = ($urandom_range(0, 2) != 0);
      inj         = ($urandom_range(0, 9) == 0);
      inj_p       = {$urandom, $urandom};
      reseed_req  = ($urandom_range(0, 39) == 0);
      reseed_seed = $urandom_range(0, 60);
      rst         = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 0; inj = 0; reseed_req = 0;
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
